uart_host_bridge: RTL
=====================

Name: uart_host_bridge

Overview:
- Byte-wide, register-mapped host-side slave that drives the UART core's FIFO and control ports.
- On the host side, a simple strobed bus accesses data, control, status and interrupt registers.
- On the UART side, it generates the active-low FIFO read/write pulses, holds the three control bytes, and pulses the control-register write enable.
- It sits between the system bus decoder and the UART core.

Parameters:
- RD_LAT, 1: clocks from n_rd_o low until rx_data_i is valid (1..3).
- CTRL1_RST, 8'h00: reset value of CTRL1 (little-endian, no parity, acq-period high nibble 0).
- CTRL2_RST, 8'h15: reset value of CTRL2 (acq-period low byte).
- CTRL3_RST, 8'h00: reset value of CTRL3 (compensation).

Ports:
- clk  in  1  system clock (40 MHz)
- rst  in  1  asynchronous reset, active-high
- cs_i  in  1  bus select; the access is qualified by wr_i or rd_i in the same cycle
- wr_i  in  1  write strobe
- rd_i  in  1  read strobe
- addr_i  in  3  register address
- wdata_i  in  8  write data
- rdata_o  out  8  read data, valid while ack_o=1
- ack_o  out  1  one-cycle access-complete pulse
- irq_o  out  1  level interrupt
- p_We_o  out  1  one-cycle control-apply pulse to the UART core
- CtrlReg1_o / CtrlReg2_o / CtrlReg3_o  out  8 each  control bytes to the UART core
- tx_data_o  out  8  TX FIFO write data
- n_we_o  out  1  TX FIFO write, active-low one-cycle pulse
- p_full_i  in  1  TX FIFO full
- rx_data_i  in  8  RX FIFO read data
- n_rd_o  out  1  RX FIFO read, active-low one-cycle pulse
- p_empty_i  in  1  RX FIFO empty

Behaviour:
- Reset values:
  - rdata_o=0, ack_o=0, irq_o=0, p_We_o=0, n_we_o=1, n_rd_o=1, tx_data_o=0.
  - CtrlRegN_o = CTRLN_RST.
  - IEN=0, sticky flags=0, FSM=IDLE.
- Register map (addr_i):
  - 0 DATA: write pushes to TX; read pops RX.
  - 1/2/3 CTRL1/2/3: R/W shadow; outputs update immediately.
  - 4 CMD: write with bit0=1 issues p_We_o; reads 0.
  - 5 STATUS (RO): bit0 p_empty_i, bit1 p_full_i, bit2 TXDROP, bit3 RXUNDER, others 0.
  - 6 IEN: bit0 RX-not-empty enable, bit1 TX-not-full enable.
  - 7 reserved: reads 0, writes ignored, still acked.
- Access acceptance:
  - An access is accepted only in IDLE with cs_i=1 and exactly one of wr_i/rd_i.
  - wr_i=rd_i=1 is ignored (no ack).
  - Strobes arriving outside IDLE are ignored; the host must wait for ack_o.
- FSM states:
  - IDLE
  - TXW: n_we_o=0 for 1 clk
  - RXR: n_rd_o=0 for 1 clk
  - RXWAIT: count RD_LAT-1 clocks
  - ACK: ack_o=1 for 1 clk, then IDLE
- Register writes and reads (addr≠0): IDLE → ACK. Ack arrives 1 clk after the strobe; the write takes effect on the strobe edge.
- DATA write:
  - If p_full_i=0: latch wdata_i into tx_data_o, IDLE→TXW→ACK. Ack arrives 2 clk after the strobe.
  - If p_full_i=1: no n_we_o pulse, set TXDROP, IDLE→ACK.
- DATA read:
  - If p_empty_i=0: IDLE→RXR→RXWAIT (skipped when RD_LAT=1)→ACK.
  - rx_data_i is sampled into rdata_o on the edge that enters ACK, exactly RD_LAT clocks after the n_rd_o assertion edge. Ack arrives RD_LAT+1 clk after the strobe.
  - If p_empty_i=1: no n_rd_o pulse, rdata_o=0, set RXUNDER, IDLE→ACK.
- CMD write with bit0=1:
  - p_We_o=1 in the cycle after the strobe, coincident with ack_o.
  - CTRL writes must precede CMD; a CTRL write in the same access is impossible.
- STATUS read:
  - Returns the flags, and TXDROP/RXUNDER clear on that same edge.
  - If a new drop or underflow coincides with the clear, the set wins.
- rdata_o holds its value after ACK until the next read ack.
- irq_o (registered) = (IEN[0] & ~p_empty_i) | (IEN[1] & ~p_full_i).
- Reset mid-access: all pulses deasserted immediately (asynchronous); the FSM returns to IDLE and no ack is issued.

Decomposition:
- Package uart_host_pkg:
  - Register address constants (ADDR_DATA..ADDR_IEN).
  - STATUS bit indices.
  - FSM state enum {IDLE, TXW, RXR, RXWAIT, ACK}.
- No sub-module needed. The register file and FSM live in one module; the RD_LAT wait counter is an inline 2-bit counter.

Test Plan:
- Reset, then read addr 1/2/3 → 8'h00, 8'h15, 8'h00. Read STATUS with p_empty_i=1, p_full_i=0 → 8'h01. Each ack arrives 1 clk after the strobe.
- Write CTRL1=8'hE3, then CMD=8'h01 → CtrlReg1_o=8'hE3 after the first access. p_We_o is high exactly 1 clk, aligned with the CMD ack.
- DATA write 8'hA5 with p_full_i=0 → tx_data_o=8'hA5 while n_we_o is low for 1 clk; ack 2 clk after the strobe. Repeat with p_full_i=1 → no n_we_o pulse; STATUS bit2=1, then reads 0 on the second STATUS read.
- RD_LAT=2, p_empty_i=0, rx_data_i=8'h3C presented 2 clk after n_rd_o low → rdata_o=8'h3C; ack 3 clk after the strobe. With p_empty_i=1 → rdata_o=0, RXUNDER set, no n_rd_o pulse.
- IEN=8'h01; toggle p_empty_i 1→0 → irq_o rises 1 clk later. Set IEN=0 → irq_o falls.
- Assert rst during RXWAIT → n_rd_o=1 and ack_o=0 immediately, with no ack after release. Also: a strobe during a busy state and wr_i=rd_i=1 are each ignored.

Source files
------------

// File: rtl/uart_host_pkg.sv
// rtl/uart_host_pkg.sv - register map, STATUS bit positions and FSM states for the UART host bridge
package uart_host_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_CTRL1  = 3'd1;
  localparam logic [2:0] ADDR_CTRL2  = 3'd2;
  localparam logic [2:0] ADDR_CTRL3  = 3'd3;
  localparam logic [2:0] ADDR_CMD    = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_IEN    = 3'd6;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_TXDROP  = 2;
  localparam int STAT_RXUNDER = 3;

  typedef enum logic [2:0] {
    IDLE,
    TXW,
    RXR,
    RXWAIT,
    ACK
  } state_e;

endpackage

// File: rtl/uart_host_bridge.sv
// rtl/uart_host_bridge.sv - strobed host register bus to UART core FIFO and control ports
module uart_host_bridge
  import uart_host_pkg::*;
#(
  parameter int         RD_LAT    = 1,
  parameter logic [7:0] CTRL1_RST = 8'h00,
  parameter logic [7:0] CTRL2_RST = 8'h15,
  parameter logic [7:0] CTRL3_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_i,
  input  logic       wr_i,
  input  logic       rd_i,
  input  logic [2:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       ack_o,
  output logic       irq_o,
  output logic       p_We_o,
  output logic [7:0] CtrlReg1_o,
  output logic [7:0] CtrlReg2_o,
  output logic [7:0] CtrlReg3_o,
  output logic [7:0] tx_data_o,
  output logic       n_we_o,
  input  logic       p_full_i,
  input  logic [7:0] rx_data_i,
  output logic       n_rd_o,
  input  logic       p_empty_i
);

  // Last RXWAIT count value before rx_data_i is sampled; unused when RD_LAT=1.
  localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d, ctrl3_q, ctrl3_d;
  logic [1:0] ien_q, ien_d;
  logic       txdrop_q, txdrop_d, rxunder_q, rxunder_d;
  logic [7:0] rdata_q, rdata_d, tx_data_q, tx_data_d;
  logic       p_we_q, p_we_d, irq_q, irq_d;
  logic       accept;

  assign accept = (state_q == IDLE) && cs_i && (wr_i ^ rd_i);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl1_d   = ctrl1_q;
    ctrl2_d   = ctrl2_q;
    ctrl3_d   = ctrl3_q;
    ien_d     = ien_q;
    txdrop_d  = txdrop_q;
    rxunder_d = rxunder_q;
    rdata_d   = rdata_q;
    tx_data_d = tx_data_q;
    p_we_d    = 1'b0;
    irq_d     = (ien_q[0] & ~p_empty_i) | (ien_q[1] & ~p_full_i);
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACK;
          if (wr_i) begin
            case (addr_i)
              ADDR_DATA: begin
                if (!p_full_i) begin
                  tx_data_d = wdata_i;
                  state_d   = TXW;
                end else begin
                  txdrop_d = 1'b1;
                end
              end
              ADDR_CTRL1: ctrl1_d = wdata_i;
              ADDR_CTRL2: ctrl2_d = wdata_i;
              ADDR_CTRL3: ctrl3_d = wdata_i;
              ADDR_CMD:   p_we_d  = wdata_i[0];
              ADDR_IEN:   ien_d   = wdata_i[1:0];
              default: ;
            endcase
          end else begin
            case (addr_i)
              ADDR_DATA: begin
                if (!p_empty_i) begin
                  state_d = RXR;
                end else begin
                  rdata_d   = 8'h00;
                  rxunder_d = 1'b1;
                end
              end
              ADDR_CTRL1: rdata_d = ctrl1_q;
              ADDR_CTRL2: rdata_d = ctrl2_q;
              ADDR_CTRL3: rdata_d = ctrl3_q;
              ADDR_STATUS: begin
                rdata_d = 8'h00;
                rdata_d[STAT_EMPTY]   = p_empty_i;
                rdata_d[STAT_FULL]    = p_full_i;
                rdata_d[STAT_TXDROP]  = txdrop_q;
                rdata_d[STAT_RXUNDER] = rxunder_q;
                txdrop_d  = 1'b0;
                rxunder_d = 1'b0;
              end
              ADDR_IEN: rdata_d = {6'b0, ien_q};
              default:  rdata_d = 8'h00;
            endcase
          end
        end
      end
      TXW: state_d = ACK;
      RXR: begin
        cnt_d = 2'd0;
        if (RD_LAT == 1) begin
          rdata_d = rx_data_i;
          state_d = ACK;
        end else begin
          state_d = RXWAIT;
        end
      end
      RXWAIT: begin
        if (cnt_q == WAIT_LAST) begin
          rdata_d = rx_data_i;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      ctrl1_q   <= CTRL1_RST;
      ctrl2_q   <= CTRL2_RST;
      ctrl3_q   <= CTRL3_RST;
      ien_q     <= 2'b00;
      txdrop_q  <= 1'b0;
      rxunder_q <= 1'b0;
      rdata_q   <= 8'h00;
      tx_data_q <= 8'h00;
      p_we_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl1_q   <= ctrl1_d;
      ctrl2_q   <= ctrl2_d;
      ctrl3_q   <= ctrl3_d;
      ien_q     <= ien_d;
      txdrop_q  <= txdrop_d;
      rxunder_q <= rxunder_d;
      rdata_q   <= rdata_d;
      tx_data_q <= tx_data_d;
      p_we_q    <= p_we_d;
      irq_q     <= irq_d;
    end
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  assign ack_o      = (state_q == ACK);
  assign n_we_o     = (state_q != TXW);
  assign n_rd_o     = (state_q != RXR);
  assign rdata_o    = rdata_q;
  assign tx_data_o  = tx_data_q;
  assign p_We_o     = p_we_q;
  assign irq_o      = irq_q;
  assign CtrlReg1_o = ctrl1_q;
  assign CtrlReg2_o = ctrl2_q;
  assign CtrlReg3_o = ctrl3_q;

endmodule
